// File: rtl/ac97_dma_sequencer.sv
// Programs the AC97 core's CSR slave for playback or record DMA, re-arming the
// block address on every DMA IRQ and walking a circular buffer per direction.
module ac97_dma_sequencer #(
  parameter int          ADDR_W      = 14,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] PLAY_BASE   = 32'h0000_0000,
  parameter logic [31:0] REC_BASE    = 32'h0001_0000,
  parameter logic [31:0] BUF_BYTES   = 32'h0000_1000,
  parameter logic [31:0] BLOCK_BYTES = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              operation,
  input  logic              play,
  input  logic              rec,
  input  logic              dmar_irq,
  input  logic              dmaw_irq,
  input  logic              csr_ack,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0] csr_data,
  output logic [31:0]       cur_addr,
  output logic [15:0]       blk_count,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_CTRL  = 3'd1;
  localparam logic [2:0] S_WR_ADDR  = 3'd2;
  localparam logic [2:0] S_WR_START = 3'd3;
  localparam logic [2:0] S_WAIT_IRQ = 3'd4;
  localparam logic [2:0] S_ADVANCE  = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;

  localparam logic [1:0] M_NONE = 2'd0;
  localparam logic [1:0] M_PLAY = 2'd1;
  localparam logic [1:0] M_REC  = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       ptr_q, ptr_d;
  logic [31:0]       cur_addr_q, cur_addr_d;
  logic [15:0]       blk_count_q, blk_count_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              irq_prev_q, irq_prev_d;
  logic              csr_we_q, csr_we_d;
  logic [ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic [DATA_W-1:0] csr_data_q, csr_data_d;

  logic [1:0]  mode_now;
  logic        mode_ok;
  logic        irq_lvl;
  logic        irq_evt;
  logic [31:0] nxt_ptr;

  function automatic logic [31:0] base_of(input logic [1:0] m);
    return (m == M_REC) ? REC_BASE : PLAY_BASE;
  endfunction

  assign mode_now = !operation       ? M_NONE :
                    (play && !rec)   ? M_PLAY :
                    (rec && !play)   ? M_REC  : M_NONE;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    cur_addr_d  = cur_addr_q;
    blk_count_d = blk_count_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    csr_we_d    = csr_we_q;
    csr_addr_d  = csr_addr_q;
    csr_data_d  = csr_data_q;
    mode_ok     = (mode_now == mode_q);
    irq_lvl     = (mode_q == M_REC) ? dmaw_irq : dmar_irq;
    irq_prev_d  = irq_lvl;
    irq_evt     = irq_lvl & ~irq_prev_q;
    nxt_ptr     = ptr_q + BLOCK_BYTES;

    case (state_q)
      S_IDLE: begin
        if (mode_now != M_NONE) begin
          state_d     = S_WR_CTRL;
          mode_d      = mode_now;
          ptr_d       = base_of(mode_now);
          blk_count_d = 16'd0;
          pending_d   = 1'b0;
          overrun_d   = 1'b0;
        end
      end
      S_WR_CTRL, S_WR_ADDR, S_WR_START, S_STOP: begin
        // A write is issued only from a cycle with csr_we low, which yields the idle gap.
        if (!csr_we_q) begin
          csr_we_d = 1'b1;
          case (state_q)
            S_WR_ADDR: begin
              csr_addr_d = (mode_q == M_REC) ? ADDR_W'(8'h14) : ADDR_W'(8'h24);
              csr_data_d = DATA_W'(ptr_q);
            end
            S_WR_START: begin
              csr_addr_d = (mode_q == M_REC) ? ADDR_W'(8'h10) : ADDR_W'(8'h20);
              csr_data_d = DATA_W'(32'h1);
            end
            S_WR_CTRL: begin
              csr_addr_d = ADDR_W'(8'h00);
              csr_data_d = DATA_W'(32'h3);
            end
            default: begin
              csr_addr_d = ADDR_W'(8'h00);
              csr_data_d = DATA_W'(32'h0);
            end
          endcase
        end else if (csr_ack) begin
          csr_we_d = 1'b0;
          case (state_q)
            S_WR_CTRL:  state_d = mode_ok ? S_WR_ADDR : S_STOP;
            S_WR_ADDR: begin
              cur_addr_d = ptr_q;
              state_d    = mode_ok ? S_WR_START : S_STOP;
            end
            S_WR_START: state_d = mode_ok ? S_WAIT_IRQ : S_STOP;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_WAIT_IRQ: begin
        if (irq_lvl || pending_q) begin
          state_d   = S_ADVANCE;
          pending_d = 1'b0;
        end else if (!mode_ok) begin
          state_d = S_STOP;
        end
      end
      S_ADVANCE: begin
        ptr_d       = (nxt_ptr == base_of(mode_q) + BUF_BYTES) ? base_of(mode_q) : nxt_ptr;
        blk_count_d = blk_count_q + 16'd1;
        state_d     = mode_ok ? S_WR_ADDR : S_STOP;
      end
      default: state_d = S_IDLE;
    endcase

    // IRQs arriving while the FSM is busy elsewhere are held for the next WAIT_IRQ visit.
    if (state_q != S_IDLE && state_q != S_WAIT_IRQ && irq_evt) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= M_NONE;
      ptr_q       <= PLAY_BASE;
      cur_addr_q  <= 32'd0;
      blk_count_q <= 16'd0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      irq_prev_q  <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      cur_addr_q  <= cur_addr_d;
      blk_count_q <= blk_count_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      irq_prev_q  <= irq_prev_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_data_q  <= csr_data_d;
    end
  end

  assign csr_we    = csr_we_q;
  assign csr_addr  = csr_addr_q;
  assign csr_data  = csr_data_q;
  assign cur_addr  = cur_addr_q;
  assign blk_count = blk_count_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule
